alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the 32-bit combinational datapath ALU.
- Adds valid/ready handshakes on input and output, registered results, and full flags: zero, negative, carry, overflow.
- Adds SLT, NOR, barrel shifts, and an iterative shift-add multiplier that takes WIDTH cycles.
- Sits between the operand/decode stage and writeback; the branch unit consumes the zero flag.

Parameters:
- WIDTH, 32, operand/result width in bits, ≥4, power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept a new operation.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; for shifts, B[SHW-1:0] is the shift amount.
- ALUOp  in  4  operation select.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- carry  out  1  carry out (ADD) or no-borrow (SUB).
- overflow  out  1  signed overflow (ADD/SUB); nonzero high product half (MUL).
- illegal  out  1  unsupported ALUOp was accepted.

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1 or 0), 1100 NOR.
  - 1000 SLL, 1001 SRL, 1010 SRA.
  - 0011 MUL (unsigned, low WIDTH bits of product).
  - All other codes are illegal.
- Reset (rst_n low, async): state IDLE; in_ready=0 while rst_n low, 1 in the first cycle after release; out_valid=0; result=0; all flags 0; mul counter=0.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
    - Accept on in_valid & in_ready.
    - Single-cycle op (incl. illegal): compute, register result and flags, go to HOLD. out_valid=1 the cycle after accept.
    - MUL: latch A into multiplicand, B into multiplier, clear accumulator, counter=0, go to BUSY.
  - BUSY: in_ready=0, out_valid=0.
    - Each cycle: if multiplier[0], add multiplicand into a 2*WIDTH accumulator; shift multiplicand left, multiplier right; counter++.
    - After WIDTH iterations, register result/flags and go to HOLD. out_valid rises exactly WIDTH+1 cycles after accept.
  - HOLD: out_valid=1, in_ready=0; result and flags stable.
    - On out_ready, go to IDLE (out_valid=0 next cycle).
    - If out_ready is already high on the first HOLD cycle, exit after that single cycle.
- Throughput: at most one operation in flight; no acceptance during BUSY/HOLD.
- Flags:
  - zero and negative are always derived from the final registered result.
  - carry and overflow are 0 for every op except ADD/SUB; overflow is also defined for MUL; carry=0 for MUL.
  - SUB carry=1 when A ≥ B unsigned.
- Illegal op: result=0, zero=1, illegal=1; illegal clears on the next accepted legal op.
- Shifts: amount is B mod WIDTH; upper bits of B ignored; SRA fills with A[WIDTH-1].
- Wrap-around: ADD/SUB/MUL results truncate to WIDTH bits.
- Reset mid-BUSY or mid-HOLD: abort immediately, return to the reset state; the in-flight result is discarded.
- in_valid held high while not ready: no effect; operands are sampled only at the accept edge.

Decomposition:
- Package alu_pkg:
  - 4-bit opcode localparams (OP_AND … OP_MUL).
  - FSM state enum {IDLE, BUSY, HOLD}.
  - Function is_legal_op.
- One sub-module: alu_mul_iter (WIDTH-cycle shift-add core with start/done).
- The single-cycle ops stay inline as a combinational case block feeding the output register.

Test Plan (WIDTH=32):
- ADD A=0xFFFFFFFF, B=1 → result 0, zero=1, carry=1, overflow=0, out_valid the cycle after accept.
- SUB A=0x80000000, B=1 → result 0x7FFFFFFF, overflow=1, carry=1, negative=0; SLT A=0xFFFFFFFE, B=1 → result 1.
- MUL A=0x00010000, B=0x00010000 → result 0, zero=1, overflow=1, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
- SRA A=0x80000000, B=0x00000024 (amount 4) → 0xF8000000; SLL A=1, B=31 → 0x80000000, negative=1.
- Backpressure: hold out_ready=0 for 5 cycles after a result → result/flags stable, in_ready=0, a new in_valid is ignored; out_ready=1 → IDLE next cycle, then accept.
- ALUOp=0101 → result 0, zero=1, illegal=1; assert rst_n=0 mid-MUL at cycle 10 → out_valid=0, result=0 asynchronously, in_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode legality check for alu_seq.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_MUL, OP_SUB,
      OP_SLT, OP_SLL, OP_SRL, OP_SRA, OP_NOR: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: operands latched on start_i, one
// partial-product step per cycle for WIDTH cycles. done_o flags the cycle in
// which the final step happens; prod_o then carries the complete product.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic               busy_q,   busy_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [SHW:0]       cnt_q,    cnt_d;
  logic               last;

  // The final step is combined with the hand-off so the caller can register
  // the product in the same edge, keeping accept-to-valid at WIDTH+1 cycles.
  assign last   = busy_q && (cnt_q == (SHW+1)'(WIDTH - 1));
  assign done_o = last;
  assign prod_o = acc_d;

  // Next-state: load on start, otherwise one shift-add step while busy.
  always_comb begin
    busy_d   = busy_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      busy_d   = 1'b1;
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, full flags and an iterative
// multiplier. One operation in flight: IDLE accepts, BUSY runs MUL, HOLD
// presents the result until the consumer takes it.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               ill_q, ill_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [WIDTH:0]     add_w, sub_w;
  logic [SHW-1:0]     shamt;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start),
    .a_i     (A),
    .b_i     (B),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // Ready is masked by reset so it reads 0 while rst_n is held low.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;

  // Single-cycle datapath; carry/overflow only meaningful for ADD/SUB.
  always_comb begin
    add_w   = {1'b0, A} + {1'b0, B};
    sub_w   = {1'b0, A} - {1'b0, B};
    shamt   = B[SHW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUOp)
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_NOR: alu_res = ~(A | B);
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = ~sub_w[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL: alu_res = A << shamt;
      OP_SRL: alu_res = A >> shamt;
      OP_SRA: alu_res = $unsigned($signed(A) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // FSM next-state and output-register load selection.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    ill_d     = ill_q;
    mul_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (ALUOp == OP_MUL) begin
            mul_start = 1'b1;
            ill_d     = 1'b0;
            state_d   = BUSY;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            neg_d    = alu_res[WIDTH-1];
            carry_d  = alu_c;
            ovf_d    = alu_v;
            ill_d    = ~is_legal_op(ALUOp);
            state_d  = HOLD;
          end
        end
      end
      BUSY: begin
        if (mul_done) begin
          result_d = mul_prod[WIDTH-1:0];
          zero_d   = (mul_prod[WIDTH-1:0] == '0);
          neg_d    = mul_prod[WIDTH-1];
          carry_d  = 1'b0;
          ovf_d    = |mul_prod[2*WIDTH-1:WIDTH];
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered result/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed table-driven bench for alu_seq at WIDTH=32, plus hand sequences
// for backpressure, first-cycle release and reset during a multiply.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic [3:0]  ALUOp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, negative, carry, overflow, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUOp     (ALUOp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .negative  (negative),
    .carry     (carry),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        z, n, c, v, ill;
    int          lat;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one operation for a single accept edge, then wait (bounded) for
  // out_valid. lat counts edges from the accept edge to out_valid high.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       output int lat, output logic rdy_seen);
    @(negedge clk);
    chk("ready_before_accept", {31'b0, in_ready}, 32'd1);
    A = a; B = b; ALUOp = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 32'hDEAD_BEEF; B = 32'h1234_5678;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Consumer takes the result; block must return to IDLE on the next edge.
  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop_after_take", {31'b0, out_valid}, 32'd0);
    chk("ready_after_take", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int   lat;
    logic rdy_seen;

    //           a             b             op       res           z     n     c     v     ill   lat
    vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 4'b0010, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[2]  = '{32'h80000000, 32'h00000001, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[3]  = '{32'h00000001, 32'h00000002, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{32'h00000005, 32'h00000005, 4'b0110, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[5]  = '{32'hFFFFFFFE, 32'h00000001, 4'b0111, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{32'h00000001, 32'hFFFFFFFE, 4'b0111, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 32'hF000F000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{32'h0F0F0000, 32'h000000F0, 4'b0001, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{32'h00000000, 32'h00000000, 4'b1100, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{32'h80000000, 32'h00000024, 4'b1010, 32'hF8000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{32'h00000001, 32'h0000001F, 4'b1000, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{32'h80000000, 32'h00000021, 4'b1001, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[13] = '{32'h7FFFFFFF, 32'h00000004, 4'b1010, 32'h07FFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[14] = '{32'h00010000, 32'h00010000, 4'b0011, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 33};
    vecs[15] = '{32'h00000003, 32'h00000005, 4'b0011, 32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 33};
    vecs[16] = '{32'hFFFFFFFF, 32'h00000002, 4'b0011, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 33};
    vecs[17] = '{32'h12345678, 32'h9ABCDEF0, 4'b0101, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[18] = '{32'hFFFFFFFF, 32'h00000001, 4'b0000, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; ALUOp = '0;

    // Reset state while rst_n is low.
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {27'b0, zero, negative, carry, overflow, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].op, lat, rdy_seen);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_ready_while_busy", i), {31'b0, rdy_seen}, 32'd0);
      chk($sformatf("v%0d_result", i), result, vecs[i].res);
      chk($sformatf("v%0d_zncvi", i), {27'b0, zero, negative, carry, overflow, illegal},
          {27'b0, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v, vecs[i].ill});
      take_result();
    end

    // Backpressure: result held for 5 cycles, a new request is ignored.
    apply(32'd2, 32'd3, 4'b0010, lat, rdy_seen);
    chk("bp_latency", lat, 1);
    @(negedge clk);
    A = 32'h11111111; B = 32'h22222222; ALUOp = 4'b0001; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", k),
          {out_valid, in_ready, zero, negative, carry, overflow, illegal, 25'b0} ^ result,
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 25'b0} ^ 32'd5);
    end
    in_valid = 1'b0;
    take_result();
    apply(32'h0000_0F00, 32'h0000_00F0, 4'b0001, lat, rdy_seen);
    chk("bp_next_result", result, 32'h0000_0FF0);

    // out_ready already high in the first HOLD cycle: single-cycle exit.
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("fast_exit_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    apply(32'd7, 32'd4, 4'b0110, lat, rdy_seen);
    chk("fast_sub_result", result, 32'd3);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("fast_exit2_valid", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a multiply; previous result (3) must be wiped.
    @(negedge clk);
    A = 32'h0001_0000; B = 32'h0001_0000; ALUOp = 4'b0011; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
    end
    chk("mid_mul_busy", {30'b0, out_valid, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_release_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("abort_no_stale_valid", {31'b0, out_valid}, 32'd0);
    apply(32'd6, 32'd7, 4'b0011, lat, rdy_seen);
    chk("post_abort_mul_latency", lat, 33);
    chk("post_abort_mul_result", result, 32'd42);
    take_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
